io_status_write_arbiter: RTL
============================

// Module: io_status_write_arbiter
// PURPOSE
//   Shares the I/O-side write port (IO_WrData/IO_WrMask/IO_WrEn/IO_Busy) of one read-clear
//   status register among NUM_REQ I/O event sources in the I/O clock domain. Each source
//   gets a one-entry holding buffer. Full buffers are granted round-robin, one write at a
//   time, and each write is paced by the register's clock-crossing busy flag.
// PARAMETERS
//   NUM_REQ     4   number of requesters, 2..16
//   DATA_WIDTH  32  status register width
// PORTS
//   Clock      in   1                   I/O-domain clock
//   Reset      in   1                   asynchronous, active-low reset
//   Req_Valid  in   NUM_REQ             requester i offers a write
//   Req_Data   in   NUM_REQ*DATA_WIDTH  write data, slice i = requester i
//   Req_Mask   in   NUM_REQ*DATA_WIDTH  bit mask per requester (1 = bit written)
//   Req_Ready  out  NUM_REQ             buffer i empty; transfer when Valid&Ready high at a rising edge
//   IO_WrData  out  DATA_WIDTH          data to the status register
//   IO_WrMask  out  DATA_WIDTH          mask to the status register
//   IO_WrEn    out  1                   one-cycle write-start pulse
//   IO_Busy    in   1                   register crossing busy; high from the cycle after IO_WrEn until done
//   Grant_Id   out  $clog2(NUM_REQ)     index of the requester behind the current or last write
// BEHAVIOUR
//   Reset (Reset=0, async)
//     - All buffers empty; Req_Ready='1.
//     - IO_WrEn=0, IO_WrData='0, IO_WrMask='0, Grant_Id=0.
//     - RR pointer = NUM_REQ-1, so requester 0 has first priority. FSM=IDLE.
//   Buffers
//     - Req_Ready[i] is registered and equals ~full[i].
//     - On Valid&Ready, data and mask are captured and full[i] is set at that edge.
//     - A buffer cleared by a grant shows Ready=1 from the next cycle. No same-cycle refill.
//   Arbitration
//     - Round-robin over full[]. Search starts at pointer+1 and wraps at NUM_REQ-1 -> 0.
//     - The winner becomes the new pointer.
//   FSM
//     IDLE:
//       - If any full[] and IO_Busy=0: latch the winner's data/mask into IO_WrData/IO_WrMask.
//       - Set Grant_Id, pulse IO_WrEn=1 for exactly 1 cycle, clear full[winner], go to WAIT_HI.
//       - If IO_Busy=1 in IDLE (busy left over from a write before reset), issue nothing.
//     WAIT_HI:
//       - Wait for IO_Busy=1, then go to WAIT_LO.
//       - If IO_Busy is still 0 two cycles after the pulse, treat the write as absorbed and go to IDLE.
//     WAIT_LO:
//       - Wait for IO_Busy=0, then go to IDLE.
//       - Arbitration is evaluated again in that IDLE cycle.
//   Timing
//     - Latency from Valid&Ready at edge k (idle, not busy) to IO_WrEn: IO_WrEn is high in cycle k+1.
//     - Back-to-back writes are spaced at least the busy duration + 2 cycles.
//   Outputs
//     - IO_WrData/IO_WrMask hold their value until the next grant.
//     - IO_WrEn is never high in two consecutive cycles.
//   Simultaneous events
//     - A grant to i and an accept into j (j != i) in the same cycle are both honoured.
//     - A new Req_Valid on i while full[i]=1 is back-pressured (Ready=0). Nothing is dropped or merged.
//   Fairness
//     - With all requesters continuously full, each gets one write per NUM_REQ grants.
//   Reset mid-operation
//     - Pending buffers are discarded.
//     - A write already pulsed completes in the register; the arbiter waits in IDLE until IO_Busy=0.
// TESTING
//   1. Reset, Req_Valid=4'b0001, Data=32'hA5, Mask=32'hFF, Busy low
//      -> IO_WrEn 1 cycle, IO_WrData=32'hA5, IO_WrMask=32'hFF, Grant_Id=0, Ready[0] low 1 cycle.
//   2. All 4 requesters valid at once, Busy held 3 cycles per write
//      -> grants in order 0,1,2,3, gaps >= 5 cycles between WrEn pulses.
//   3. Requester 2 re-offers a write while full, during another's write
//      -> Ready[2]=0 until its grant, accepted the cycle after, nothing lost.
//   4. Pointer=3, requesters 0 and 3 full -> grant 0 first (wrap-around), then 3.
//   5. IO_Busy held high for 20 cycles after a pulse
//      -> no second IO_WrEn until Busy low, then next grant within 2 cycles.
//   6. Assert Reset in WAIT_LO with 2 buffers full
//      -> all outputs at reset values, Ready='1, no IO_WrEn until Busy low and a new Valid arrives.

Source files
------------

// File: rtl/io_status_write_arbiter.sv
// Round-robin arbiter sharing the I/O-side write port of a read-clear status register.
// Each requester owns a one-entry buffer; writes are paced by the register's busy flag.

module io_status_write_arbiter_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [DATA_WIDTH-1:0] mask,
    input  logic                  clear,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] heldData,
    output logic [DATA_WIDTH-1:0] heldMask
);
    // Accept only into an empty slot, so a clear and a refill never share a cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            full     <= 1'b0;
            heldData <= '0;
            heldMask <= '0;
        end else if (valid && !full) begin
            full     <= 1'b1;
            heldData <= data;
            heldMask <= mask;
        end else if (clear) begin
            full     <= 1'b0;
        end
    end
endmodule

module io_status_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic [NUM_REQ-1:0]               Req_Valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    Req_Data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    Req_Mask,
    output logic [NUM_REQ-1:0]               Req_Ready,
    output logic [DATA_WIDTH-1:0]            IO_WrData,
    output logic [DATA_WIDTH-1:0]            IO_WrMask,
    output logic                             IO_WrEn,
    input  logic                             IO_Busy,
    output logic [$clog2(NUM_REQ)-1:0]       Grant_Id
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

    state_t                               state;
    logic   [IW-1:0]                      ptr;
    logic   [1:0]                         hiCnt;
    logic   [NUM_REQ-1:0]                 full;
    logic   [NUM_REQ-1:0]                 clear;
    logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] slotData;
    logic   [NUM_REQ-1:0][DATA_WIDTH-1:0] slotMask;
    logic   [IW-1:0]                      winner;
    logic   [IW:0]                        cand;
    logic                                 found;
    logic                                 grant;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gSlot
        io_status_write_arbiter_slot #(.DATA_WIDTH(DATA_WIDTH)) uSlot (
            .Clock    (Clock),
            .Reset    (Reset),
            .valid    (Req_Valid[gi]),
            .data     (Req_Data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .mask     (Req_Mask[gi*DATA_WIDTH +: DATA_WIDTH]),
            .clear    (clear[gi]),
            .full     (full[gi]),
            .heldData (slotData[gi]),
            .heldMask (slotMask[gi])
        );
    end

    assign Req_Ready = ~full;

    // Search starts one past the last winner and wraps, giving rotating priority.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ))
                cand = cand - (IW+1)'(NUM_REQ);
            if (!found && full[cand[IW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IW-1:0];
            end
        end
    end

    assign grant = (state == IDLE) && found && !IO_Busy;
    assign clear = grant ? (NUM_REQ'(1) << winner) : '0;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            ptr       <= IW'(NUM_REQ-1);
            hiCnt     <= '0;
            IO_WrEn   <= 1'b0;
            IO_WrData <= '0;
            IO_WrMask <= '0;
            Grant_Id  <= '0;
        end else begin
            IO_WrEn <= 1'b0;
            case (state)
                IDLE: if (grant) begin
                    IO_WrData <= slotData[winner];
                    IO_WrMask <= slotMask[winner];
                    Grant_Id  <= winner;
                    ptr       <= winner;
                    IO_WrEn   <= 1'b1;
                    hiCnt     <= '0;
                    state     <= WAIT_HI;
                end
                // Busy that never rises means the crossing absorbed the write immediately.
                WAIT_HI: begin
                    if (IO_Busy)
                        state <= WAIT_LO;
                    else if (hiCnt == 2'd2)
                        state <= IDLE;
                    else
                        hiCnt <= hiCnt + 2'd1;
                end
                WAIT_LO: if (!IO_Busy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
